// File: rtl/apb_master_ctrl.sv
// APB4 requester: valid/ready command stream in, SETUP/ACCESS transfers out, one response per command.
// Optional wait-state watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    output logic [2:0]        PPROT,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   live;
    logic   accept;
    logic   done;
    logic   abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // The edge that would bring the count to TIMEOUT aborts; PREADY on that edge wins.
    assign abort = (state == ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign abort          = 1'b0;
`endif

    // live keeps cmd_ready low while PRESETn is asserted without a combinational reset path.
    assign cmd_ready = live && (state == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (done || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
            PSTRB  <= '0;
            PPROT  <= '0;
        end else if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : '0;
            PPROT  <= cmd_prot;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: reference memory predicts responses, a monitor pops and compares.
module tb_apb_master_ctrl;

    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        PCLK, PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
    } exp_t;

    typedef struct {
        int waits;
        bit err;
    } plan_t;

    exp_t        exp_q[$];
    plan_t       plan_q[$];
    logic [31:0] ref_mem[256];
    logic [31:0] slv_mem[256];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int next_hold = -1;

    logic        cur_write;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_strb;
    logic [2:0]  cur_prot;
    int          cur_acc = -10;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    // Slave model: plan-driven wait states and errors, junk on PRDATA/PSLVERR outside completion.
    initial begin
        int wait_left;
        bit err_now;
        plan_t p;
        wait_left = 0;
        err_now   = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn || !PSEL) begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end else if (!PENABLE) begin
                if (plan_q.size() == 0) begin
                    chk("slave_plan_available", 0, 1);
                    wait_left = 0; err_now = 0;
                end else begin
                    p = plan_q.pop_front();
                    wait_left = p.waits; err_now = p.err;
                end
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end else if (wait_left == 0) begin
                PREADY  = 1'b1;
                PSLVERR = err_now;
                PRDATA  = PWRITE ? $urandom : slv_mem[PADDR];
                if (PWRITE && !err_now)
                    for (int b = 0; b < 4; b++)
                        if (PSTRB[b]) slv_mem[PADDR][8*b +: 8] = PWDATA[8*b +: 8];
            end else begin
                wait_left--;
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    // Bus monitor: address phase fields must match the accepted command for the whole transfer.
    initial forever begin
        @(negedge PCLK);
        if (PRESETn && PSEL) begin
            chk("apb_fields", {PWRITE, PADDR, PWDATA, PSTRB, PPROT},
                {cur_write, cur_addr, cur_wdata, cur_write ? cur_strb : 4'h0, cur_prot});
            chk("apb_penable", PENABLE, (cyc != cur_acc));
        end
    end

    // Response monitor: pops the scoreboard, checks hold stability, drives rsp_ready.
    initial begin
        bit   seen;
        int   hold, cnt;
        exp_t e;
        logic [33:0] held;
        seen = 0; hold = 0; cnt = 0; held = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                seen = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                chk("cmd_ready_while_rsp", cmd_ready, 0);
                if (!seen) begin
                    seen = 1; cnt = 0;
                    held = {rsp_rdata, rsp_slverr, rsp_timeout};
                    hold = (next_hold >= 0) ? next_hold : int'($urandom_range(0, 3));
                    next_hold = -1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_slverr", rsp_slverr, e.err);
                        chk("rsp_timeout", rsp_timeout, e.to);
                        chk("rsp_latency", 64'(cyc - cur_acc), 64'(e.lat));
                    end
                end else begin
                    chk("rsp_stable", {rsp_rdata, rsp_slverr, rsp_timeout}, held);
                end
                rsp_ready = (cnt >= hold);
                cnt++;
            end else begin
                seen = 0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         input int waits, input bit err, input bit expect_rsp);
        exp_t e;
        bit   got;
        bit   timed;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge PCLK);
            if (cmd_ready) got = 1;
        end
        if (!got) begin
            chk("cmd_accept_wait", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        cur_write = w; cur_addr = a; cur_wdata = d; cur_strb = s; cur_prot = p;
        cur_acc = cyc + 1;
        plan_q.push_back('{waits: waits, err: err});
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1)); cmd_addr = 8'($urandom);
        cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
        timed   = TO_EN && (waits >= TO);
        e.to    = timed;
        e.err   = err || timed;
        e.lat   = timed ? 1 + TO : 2 + waits;
        e.rdata = (w || timed) ? 32'h0 : ref_mem[a];
        if (expect_rsp) begin
            if (w && !err && !timed)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge PCLK);
            if (exp_q.size() == 0 && !rsp_valid) ok = 1;
        end
        if (!ok) begin
            chk("drain", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        chk(nm, {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, cmd_ready,
                 rsp_valid, rsp_slverr, rsp_timeout}, 0);
        chk({nm, "_data"}, {PWDATA, rsp_rdata}, 0);
    endtask

    initial begin
        logic [31:0] d;
        int          w;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            slv_mem[i] = 32'h0;
        end
        ref_mem[8] = 32'h1234_5678;
        slv_mem[8] = 32'h1234_5678;
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0;
        #2;
        check_outputs_zero("reset_state");
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Zero-wait write, 3-wait read, error write held for 4 cycles.
        issue(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 0, 1);
        drain();
        issue(1'b0, 8'h08, 32'h0, 4'hF, 3'b001, 3, 0, 1);
        drain();
        next_hold = 4;
        issue(1'b1, 8'h0C, 32'h0BAD_F00D, 4'h5, 3'b100, 1, 1, 1);
        drain();

        // Back-to-back write then read of 0x00.
        d = $urandom;
        issue(1'b1, 8'h00, d, 4'hF, 3'b000, 0, 0, 1);
        next_hold = 0;
        issue(1'b0, 8'h00, 32'h0, 4'h0, 3'b000, 0, 0, 1);
        drain();

        if (TO_EN) begin
            issue(1'b0, 8'h08, 32'h0, 4'h0, 3'b000, 50, 0, 1);
            drain();
            issue(1'b0, 8'h08, 32'h0, 4'h0, 3'b000, TO - 1, 0, 1);
            drain();
            issue(1'b1, 8'h04, 32'h1111_2222, 4'hF, 3'b000, TO, 0, 1);
            drain();
        end

        // Reset in the middle of ACCESS drops the write and produces no response.
        issue(1'b1, 8'h10, 32'hA5A5_A5A5, 4'hF, 3'b000, 100000, 0, 0);
        @(posedge PCLK);
        @(posedge PCLK); #3;
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("no_rsp_after_reset", rsp_valid, 0);
        chk("cmd_ready_after_mid_reset", cmd_ready, 1);
        issue(1'b0, 8'h10, 32'h0, 4'h0, 3'b011, 0, 0, 1);
        drain();

        for (int n = 0; n < 80; n++) begin
            w = TO_EN ? int'($urandom_range(0, TO + 1)) : int'($urandom_range(0, 5));
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4) * 4), $urandom,
                  4'($urandom), 3'($urandom), w, ($urandom_range(0, 9) == 0), 1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
